// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator for the data memory; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module load_store_unit #(
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  load_type,
  output logic [2:0]  store_type,
  output logic [31:0] ram_address,
  output logic [31:0] data_in,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_fault,
  output logic [31:0] fault_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic is_store, kill, accept, misalign, timeout;
  assign accept = !reset && state == IDLE && ex_valid && (ex_is_load || ex_is_store) && !flush;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (ex_funct3[1:0] == 2'b01 && ex_addr[0]) || (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign timeout = state == WAIT && mem_busy && cnt == CW'(BUSY_TIMEOUT - 1);
  assign mem_read_en = state == ISSUE && !is_store;
  assign mem_write_en = state == ISSUE && is_store;
  assign load_type = funct3;
  assign store_type = funct3;
  assign lsu_stall = state != IDLE || accept;
  always_comb begin
    state_nx = state == IDLE  ? ((accept && !misalign) ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (timeout ? IDLE : (mem_busy ? WAIT : RESP)) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      funct3 <= '0;
      rd <= '0;
      is_store <= 1'b0;
      kill <= 1'b0;
      ram_address <= '0;
      data_in <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      lsu_fault <= 1'b0;
      fault_addr <= '0;
    end else begin
      state <= state_nx;
      wb_valid <= 1'b0;
      lsu_fault <= 1'b0;
      if (accept && !misalign) begin
        ram_address <= ex_addr;
        data_in <= ex_store_data;
        funct3 <= ex_funct3;
        rd <= ex_rd;
        is_store <= ex_is_store && !ex_is_load;
        kill <= 1'b0;
        cnt <= '0;
      end
      if (state != IDLE && flush) kill <= 1'b1;
      if (state == WAIT && mem_busy) cnt <= cnt + 1'b1;
      if (timeout || (accept && misalign)) begin
        lsu_fault <= 1'b1;
        fault_addr <= timeout ? ram_address : ex_addr;
      end
      // a flush arriving in RESP itself still suppresses the writeback
      if (state == RESP && !is_store) begin
        wb_valid <= !(kill || flush);
        wb_rd <= rd;
        wb_data <= funct3 == 3'b100 ? {24'b0, mem_rdata[7:0]} :
                   funct3 == 3'b101 ? {16'b0, mem_rdata[15:0]} : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0, mem_busy = 1'b0;
  logic [2:0] ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_store_data = '0, mem_rdata = '0;
  logic [4:0] ex_rd = '0;
  logic mem_read_en, mem_write_en, lsu_stall, wb_valid, lsu_fault;
  logic [2:0] load_type, store_type;
  logic [31:0] ram_address, data_in, wb_data, fault_addr;
  logic [4:0] wb_rd;
  int checks = 0, failures = 0;
  int rd_n, wr_n, stall_n, fault_n;
  logic [31:0] s_addr, s_data, f_addr;
  logic [2:0] s_type;
  logic [36:0] exp_q[$];

  load_store_unit #(.BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .load_type(load_type), .store_type(store_type),
    .ram_address(ram_address), .data_in(data_in), .lsu_stall(lsu_stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .lsu_fault(lsu_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (wb_valid) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e[36:32]));
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] rdata, input logic [4:0] rd,
                    input int busy, input logic fl);
    rd_n = 0; wr_n = 0; stall_n = 0; fault_n = 0;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_store_data = d; ex_rd = rd; mem_rdata = rdata;
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    for (int c = 0; c < 14; c++) begin
      mem_busy = c >= 1 && c <= busy;
      flush = fl && c == 1;
      #1;
      rd_n += int'(mem_read_en);
      wr_n += int'(mem_write_en);
      stall_n += int'(lsu_stall);
      fault_n += int'(lsu_fault);
      if (mem_read_en || mem_write_en) begin
        s_addr = ram_address; s_data = data_in; s_type = mem_read_en ? load_type : store_type;
      end
      if (lsu_fault) f_addr = fault_addr;
      tick;
    end
    mem_busy = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_en", 32'(mem_read_en), 0);
    chk("rst_write_en", 32'(mem_write_en), 0);
    chk("rst_load_type", 32'(load_type), 0);
    chk("rst_store_type", 32'(store_type), 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fault", 32'(lsu_fault), 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_stall", 32'(lsu_stall), 0);
    reset = 1'b0;
    tick;
    // LW with exact cycle-by-cycle timing
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h10; ex_rd = 5'd5;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_accept_stall", 32'(lsu_stall), 1);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("lw_read_en", 32'(mem_read_en), 1);
    chk("lw_write_en", 32'(mem_write_en), 0);
    chk("lw_load_type", 32'(load_type), 32'h2);
    chk("lw_address", ram_address, 32'h10);
    tick;
    chk("lw_strobe_drop", 32'(mem_read_en), 0);
    chk("lw_wait_stall", 32'(lsu_stall), 1);
    tick;
    chk("lw_resp_no_wb", 32'(wb_valid), 0);
    tick;
    chk("lw_latency", 32'(wb_valid), 1);
    tick;
    chk("lw_wb_pulse", 32'(wb_valid), 0);
    // SB
    op(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 5'd3, 0, 1'b0);
    chk("sb_write_pulses", 32'(wr_n), 1);
    chk("sb_read_pulses", 32'(rd_n), 0);
    chk("sb_store_type", 32'(s_type), 0);
    chk("sb_address", s_addr, 32'h13);
    chk("sb_data", s_data, 32'hA5);
    chk("sb_stall_cycles", 32'(stall_n), 3);
    // sub-word extension
    exp_q.push_back({5'd7, 32'h00008001});
    op(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'hFFFF8001, 5'd7, 0, 1'b0);
    chk("lhu_load_type", 32'(s_type), 32'h5);
    exp_q.push_back({5'd8, 32'hFFFF8001});
    op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 5'd8, 0, 1'b0);
    exp_q.push_back({5'd9, 32'h00000080});
    op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'hFFFFFF80, 5'd9, 0, 1'b0);
    exp_q.push_back({5'd10, 32'hFFFFFF80});
    op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 5'd10, 0, 1'b0);
    // memory busy for three WAIT cycles
    exp_q.push_back({5'd11, 32'h12345678});
    op(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 32'h12345678, 5'd11, 3, 1'b0);
    chk("busy_stall_cycles", 32'(stall_n), 6);
    chk("busy_read_pulses", 32'(rd_n), 1);
    // load and store both set acts as a load
    exp_q.push_back({5'd12, 32'hCAFEF00D});
    op(1'b1, 1'b1, 3'b010, 32'h40, 32'h55, 32'hCAFEF00D, 5'd12, 0, 1'b0);
    chk("both_read_pulses", 32'(rd_n), 1);
    chk("both_write_pulses", 32'(wr_n), 0);
    // flush in WAIT kills the writeback only
    op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11112222, 5'd13, 0, 1'b1);
    chk("flush_read_pulses", 32'(rd_n), 1);
    chk("flush_idle", 32'(lsu_stall), 0);
    exp_q.push_back({5'd14, 32'h33334444});
    op(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'h33334444, 5'd14, 0, 1'b0);
    // misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    op(1'b1, 1'b0, 3'b010, 32'h21, 32'h0, 32'h0BADF00D, 5'd16, 0, 1'b0);
    chk("mis_read_pulses", 32'(rd_n), 0);
    chk("mis_fault", 32'(fault_n), 1);
    chk("mis_fault_addr", f_addr, 32'h21);
`else
    exp_q.push_back({5'd16, 32'h0BADF00D});
    op(1'b1, 1'b0, 3'b010, 32'h21, 32'h0, 32'h0BADF00D, 5'd16, 0, 1'b0);
    chk("mis_read_pulses", 32'(rd_n), 1);
    chk("mis_address", s_addr, 32'h21);
    chk("mis_no_fault", 32'(fault_n), 0);
`endif
    // busy timeout
    op(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h99999999, 5'd15, 20, 1'b0);
    chk("to_fault_pulses", 32'(fault_n), 1);
    chk("to_fault_addr", f_addr, 32'h50);
    chk("to_stall_cycles", 32'(stall_n), 9);
    // reset mid-WAIT
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h30; ex_rd = 5'd17;
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0; mem_busy = 1'b1;
    tick;
    reset = 1'b1;
    #1;
    chk("rw_stall", 32'(lsu_stall), 0);
    chk("rw_ram_address", ram_address, 0);
    chk("rw_load_type", 32'(load_type), 0);
    chk("rw_wb_data", wb_data, 0);
    chk("rw_wb_rd", 32'(wb_rd), 0);
    chk("rw_fault_addr", fault_addr, 0);
    chk("rw_data_in", data_in, 0);
    tick;
    reset = 1'b0; mem_busy = 1'b0;
    tick;
    // reset mid-ISSUE drops the strobe at once
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_addr = 32'h34;
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("ri_strobe_before", 32'(mem_read_en), 1);
    reset = 1'b1;
    #1;
    chk("ri_strobe_after", 32'(mem_read_en), 0);
    tick;
    reset = 1'b0;
    repeat (6) tick;
    chk("wb_pending", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the synchronous data memory. It accepts one load or store per transaction from the execute stage and drives the memory request lines (`mem_read_en`, `mem_write_en`, `load_type`, `store_type`, `ram_address`, `data_in`). It tracks completion through `mem_busy`, returns load data to writeback, and stalls the pipeline while a transaction is in flight.

## Interface
Parameters:
- BUSY_TIMEOUT, 8: maximum WAIT cycles with `mem_busy` high before a timeout fault.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill a pending load writeback; block acceptance this cycle.
- ex_valid  in  1  execute-stage op valid.
- ex_is_load  in  1  op is a load.
- ex_is_store  in  1  op is a store.
- ex_funct3  in  3  RV32 funct3: LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010.
- ex_addr  in  32  effective byte address.
- ex_store_data  in  32  rs2 value.
- ex_rd  in  5  load destination register.
- mem_rdata  in  32  memory `data_out`.
- mem_busy  in  1  memory busy flag.
- mem_read_en, mem_write_en  out  1  request strobes.
- load_type, store_type  out  3  funct3 forwarded to memory.
- ram_address  out  32  byte address.
- data_in  out  32  store data.
- lsu_stall  out  1  hold upstream stages.
- wb_valid  out  1  one-cycle load writeback strobe.
- wb_rd  out  5  load destination register.
- wb_data  out  32  load result.
- lsu_fault  out  1  one-cycle fault pulse.
- fault_addr  out  32  address of the faulting access.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when `ex_valid && (ex_is_load || ex_is_store) && !flush`.
  - On that edge, register the address, funct3, data, rd and a load/store flag.
  - If `ex_is_load` and `ex_is_store` are both set, the op is treated as a load.
- ISSUE: exactly one `mem_read_en` or `mem_write_en` pulse, with the registered fields on the memory lines. Next state is WAIT.
- WAIT: hold while `mem_busy == 1`. When `mem_busy == 0` → RESP.
  - Timeout: the counter reaches BUSY_TIMEOUT → `lsu_fault` pulse, `fault_addr` = address, → IDLE, no writeback.
- RESP: capture `mem_rdata`.
  - LBU forces `wb_data[31:8] = 0`; LHU forces `wb_data[31:16] = 0`. All other load types pass through unchanged.
  - For loads not killed: `wb_valid` = 1 next cycle, `wb_rd` = registered rd.
  - → IDLE.
- Store transactions never assert `wb_valid`.
- Flush while in ISSUE, WAIT or RESP:
  - Sets a kill flag; a load completes its memory handshake with `wb_valid` suppressed.
  - A store already in ISSUE still writes; it is not cancelled.
- `lsu_stall` (combinational) = `(state != IDLE) || accept_condition`.
- Strobes are low in every state except ISSUE. Address and data lines hold their last value.

## Timing
- Accept at edge E0. ISSUE during cycle 1; memory samples the strobe at E1. WAIT during cycle 2 (`mem_busy` = 1). RESP during cycle 3 (`mem_busy` = 0, data valid). `wb_valid` high during cycle 4.
- Load-to-writeback latency: 4 cycles. Store occupancy: 3 cycles (IDLE → IDLE). Back-to-back accept is allowed in the IDLE cycle after RESP.
- `wb_valid` and `lsu_fault` are registered, single-cycle pulses.
- Reset (asynchronous, any state) → IDLE. All outputs are 0: strobes, types, `ram_address`, `data_in`, `wb_valid`, `wb_rd`, `wb_data`, `lsu_fault`, `fault_addr`, `lsu_stall`. The kill flag and timeout counter also clear.
- Reset mid-ISSUE drops the strobe immediately. A partial write is the memory's concern.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: at acceptance, halfword with `addr[0] = 1`, or word with `addr[1:0] != 0`:
  - skip ISSUE, issue no strobe;
  - `lsu_fault` pulses the cycle after accept, with `fault_addr` = address;
  - → IDLE.
- Undefined: misaligned accesses are issued unchanged (the memory ignores the low address bits); `lsu_fault` is driven only by timeout.

## Test plan
- LW at 0x10 with memory word 0xDEADBEEF, rd = 5 → one `mem_read_en` pulse with `load_type = 010`; `wb_valid` 4 cycles after accept; `wb_data = 0xDEADBEEF`, `wb_rd = 5`.
- SB at 0x13 with data 0x000000A5 → one `mem_write_en` pulse with `store_type = 000`, `ram_address = 0x13`; no `wb_valid`; `lsu_stall` high for 3 cycles.
- LHU at 0x12 with word 0x8001xxxx → `wb_data = 0x00008001`. LH on the same word → `0xFFFF8001`.
- Load at 0x20, flush asserted in WAIT → handshake completes, `wb_valid` stays 0, FSM returns to IDLE.
- `mem_busy` held at 1 → `lsu_fault` after 8 WAIT cycles with `fault_addr` = address, no writeback. Reset asserted mid-WAIT → all outputs 0 in the same cycle.
- With `LSU_MISALIGN_TRAP_EN` defined: LW at 0x21 → no strobe, `lsu_fault` pulse, `fault_addr = 0x21`. With the macro undefined: the strobe is issued with `ram_address = 0x21`.
